// File: rtl/pulse_mask_analyzer.sv
// pulse_mask_analyzer: hysteresis mask recovery with period/high-time measurement and stuck detection
module pulse_mask_analyzer #(
    parameter logic signed [15:0] THRESH_HI = 16'sd8192,
    parameter logic signed [15:0] THRESH_LO = -16'sd8192,
    parameter logic [31:0]        TIMEOUT   = 32'd1250000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] sigIn,
    input  logic               enable,
    output logic               maskOut,
    output logic [31:0]        period,
    output logic [31:0]        highWidth,
    output logic               measValid,
    output logic               stuck
);
    typedef enum logic [1:0] {IDLE, SEEK, MEASURE} state_t;
    state_t      state, state_n;
    logic [31:0] period_cnt, high_cnt, period_cnt_n, high_cnt_n;
    logic [31:0] period_inc, high_inc;
    logic        mask_n, rise, stuck_n, publish;
    assign mask_n     = (sigIn >= THRESH_HI) ? 1'b1 : (sigIn <= THRESH_LO) ? 1'b0 : maskOut;
    assign rise       = !maskOut && mask_n;
    assign period_inc = period_cnt + {31'd0, period_cnt != '1};
    assign high_inc   = high_cnt + {31'd0, high_cnt != '1};
    // In SEEK, period_cnt doubles as the dwell counter for stuck detection
    always_comb begin
        state_n      = state;
        period_cnt_n = period_cnt;
        high_cnt_n   = high_cnt;
        stuck_n      = stuck;
        publish      = 1'b0;
        if (!enable) begin
            state_n      = IDLE;
            period_cnt_n = '0;
            high_cnt_n   = '0;
            stuck_n      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n      = SEEK;
                    period_cnt_n = '0;
                    high_cnt_n   = '0;
                end
                SEEK: begin
                    if (rise) begin
                        state_n      = MEASURE;
                        period_cnt_n = 32'd1;
                        high_cnt_n   = 32'd1;
                    end else if (period_cnt >= TIMEOUT) begin
                        stuck_n      = 1'b1;
                        period_cnt_n = '0;
                    end else begin
                        period_cnt_n = period_inc;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        publish      = 1'b1;
                        stuck_n      = 1'b0;
                        period_cnt_n = 32'd1;
                        high_cnt_n   = 32'd1;
                    end else if (period_cnt >= TIMEOUT) begin
                        state_n      = SEEK;
                        stuck_n      = 1'b1;
                        period_cnt_n = '0;
                        high_cnt_n   = '0;
                    end else begin
                        period_cnt_n = period_inc;
                        high_cnt_n   = mask_n ? high_inc : high_cnt;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    // Comparator register runs independently of enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) maskOut <= 1'b0;
        else       maskOut <= mask_n;
    end
    // FSM, counters and published measurements
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            stuck      <= 1'b0;
            measValid  <= 1'b0;
            period     <= '0;
            highWidth  <= '0;
        end else begin
            state      <= state_n;
            period_cnt <= period_cnt_n;
            high_cnt   <= high_cnt_n;
            stuck      <= stuck_n;
            measValid  <= publish;
            period     <= publish ? period_cnt : period;
            highWidth  <= publish ? high_cnt : highWidth;
        end
    end
endmodule

// File: doc/pulse_mask_analyzer.md
PULSE_MASK_ANALYZER -- requirements
Module: pulse_mask_analyzer

Interface
REQ-001 SHALL have parameter THRESH_HI, default 16'sd8192, signed rising threshold on sigIn.
REQ-002 SHALL have parameter THRESH_LO, default -16'sd8192, signed falling threshold; THRESH_LO < THRESH_HI.
REQ-003 SHALL have parameter TIMEOUT, default 32'd1250000, cycles without a rising edge before a stuck condition is declared.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port sigIn  input  16  signed analog mask waveform, e.g. from a pulse mask generator DAC output.
REQ-007 SHALL have port enable  input  1  measurement enable, level-sensitive.
REQ-008 SHALL have port maskOut  output  1  recovered mask level.
REQ-009 SHALL have port period  output  32  unsigned; last measured rising-to-rising interval in cycles (divider estimate).
REQ-010 SHALL have port highWidth  output  32  unsigned; last measured high time in cycles (duty estimate).
REQ-011 SHALL have port measValid  output  1  one-cycle strobe on each new period/highWidth.
REQ-012 SHALL have port stuck  output  1  no rising edge within TIMEOUT cycles.

Function
REQ-013 SHALL register maskOut through a hysteresis comparator.
- Next value 1 when sigIn >= THRESH_HI.
- Next value 0 when sigIn <= THRESH_LO.
- Otherwise hold.
- Latency sigIn to maskOut: 1 cycle.
REQ-014 SHALL update maskOut regardless of enable.
REQ-015 SHALL define a rise event as: maskOut = 0 and comparator next value = 1.
REQ-016 SHALL implement states IDLE, SEEK and MEASURE.
REQ-017 SHALL move IDLE to SEEK when enable = 1. Any state SHALL move to IDLE when enable = 0.
REQ-018 SHALL, in IDLE, clear periodCnt/highCnt and stuck and hold measValid = 0. period and highWidth SHALL hold their values.
REQ-019 SHALL, on a rise event in SEEK, load periodCnt = 1 and highCnt = 1, move to MEASURE, and publish nothing.
REQ-020 SHALL, in MEASURE with no rise event:
- increment periodCnt every cycle;
- increment highCnt when the comparator next value is 1.
REQ-021 SHALL, on a rise event in MEASURE:
- load period = periodCnt and highWidth = highCnt;
- pulse measValid for 1 cycle, coincident with the first cycle maskOut = 1;
- clear stuck;
- reload both counters to 1.
REQ-022 SHALL saturate periodCnt and highCnt at 32'hFFFFFFFF; they SHALL never wrap.
REQ-023 SHALL, when periodCnt >= TIMEOUT in MEASURE, or the SEEK dwell >= TIMEOUT, with no rise event:
- set stuck = 1;
- return to SEEK;
- discard the partial counts;
- leave period and highWidth unchanged.
REQ-024 SHALL give a rise event priority over timeout when both occur in the same cycle.
REQ-025 SHALL give enable = 0 priority over rise and timeout events when they occur in the same cycle.
REQ-026 SHALL hold stuck = 1 through SEEK until the next published measurement or IDLE. maskOut indicates the stuck level (always-high or always-low mask).
REQ-027 SHALL use a minimum measurable period of 2 cycles (alternating high/low sigIn) and SHALL report period = 2, highWidth = 1 in that case.

Reset
REQ-028 SHALL, while reset = 1, immediately force: state IDLE, maskOut 0, period 0, highWidth 0, measValid 0, stuck 0, periodCnt and highCnt 0.
REQ-029 SHALL, on reset assertion mid-measurement, abandon the measurement and discard the partial counts. After release with enable = 1, the first rise event SHALL re-arm only (REQ-019).

Verification
REQ-030 SHALL pass: enable = 1; sigIn = 16'h7fff for 3 cycles, then 16'h8000 for 7 cycles, repeated -> from the second rise on, measValid every 10 cycles with period = 10, highWidth = 3.
REQ-031 SHALL pass: sigIn toggles 16'h7fff/16'h8000 every cycle -> period = 2, highWidth = 1, measValid every 2 cycles.
REQ-032 SHALL pass: sigIn hovers at 0 between threshold crossings (+9000 -> 0 -> -9000 -> 0 -> +9000) -> maskOut changes only at ±9000; no extra measValid.
REQ-033 SHALL pass: TIMEOUT = 100; sigIn held 16'h7fff after one rise -> stuck = 1 at count 100, maskOut = 1, period unchanged. A later valid two-rise sequence -> stuck = 0 with measValid.
REQ-034 SHALL pass: enable dropped for 5 cycles mid-period, then raised -> no measValid until two further rises; period and highWidth retained across IDLE.
REQ-035 SHALL pass: reset pulsed asynchronously mid-MEASURE (between clk edges) -> all outputs 0 immediately; the first post-reset rise produces no measValid.
